// File: rtl/core_regfile_sb.sv
// Multi-port integer register file with same-cycle write forwarding and a per-register
// busy scoreboard for long-latency results.
module core_regfile_sb #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned NREGS      = 32,
   parameter int unsigned NRD        = 3,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned RESET_REGS = 0,
   localparam int unsigned AW        = $clog2(NREGS)
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   input  logic [NRD*AW-1:0]     rs_addr,
   output logic [NRD*XLEN-1:0]   rs_data,
   output logic [NRD-1:0]        rs_busy,
   input  logic                  wa_en,
   input  logic [AW-1:0]         wa_addr,
   input  logic [XLEN-1:0]       wa_data,
   input  logic                  wb_en,
   input  logic [AW-1:0]         wb_addr,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  lock_en,
   input  logic [AW-1:0]         lock_addr,
   input  logic                  flush,
   output logic                  busy_any
);

   localparam bit ZeroEn  = (ZERO_REG != 0);
   localparam bit ResetEn = (RESET_REGS != 0);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   logic wa_ok;
   logic wb_ok;
   logic lock_ok;

   assign wa_ok   = wa_en && !(ZeroEn && (wa_addr == '0));
   assign wb_ok   = wb_en && !(ZeroEn && (wb_addr == '0));
   assign lock_ok = lock_en && !(ZeroEn && (lock_addr == '0));

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (!g_resetn) begin
         busy_d = '0;
         if (ResetEn) begin
            for (int i = 0; i < int'(NREGS); i++) begin
               regs_d[i] = '0;
            end
         end
      end else begin
         // Port B first so port A overwrites it on an address collision.
         if (wb_ok) begin
            regs_d[wb_addr] = wb_data;
            busy_d[wb_addr] = 1'b0;
         end
         if (wa_ok) begin
            regs_d[wa_addr] = wa_data;
         end
         if (lock_ok) begin
            busy_d[lock_addr] = 1'b1;
         end
         if (flush) begin
            busy_d = '0;
         end
      end
   end

   always_ff @(posedge g_clk) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
   end

   for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          is_zero;

      assign addr    = rs_addr[k*AW +: AW];
      assign is_zero = ZeroEn && (addr == '0);

      always_comb begin
         if (is_zero) begin
            rs_data[k*XLEN +: XLEN] = '0;
         end else if (wa_en && (wa_addr == addr)) begin
            rs_data[k*XLEN +: XLEN] = wa_data;
         end else if (wb_en && (wb_addr == addr)) begin
            rs_data[k*XLEN +: XLEN] = wb_data;
         end else begin
            rs_data[k*XLEN +: XLEN] = regs_q[addr];
         end
      end

      // A same-cycle writeback releases the dependency without waiting for the edge.
      assign rs_busy[k] = busy_q[addr] && !(wb_en && (wb_addr == addr)) && !is_zero;
   end

   assign busy_any = |busy_q;

endmodule

// File: doc/core_regfile_sb.md
CORE_REGFILE_SB -- requirements
Module: core_regfile_sb

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning register data width in bits.
REQ-002 The module SHALL have parameter NREGS, default 32, meaning architectural register count (power of two, 2..64); AW = clog2(NREGS).
REQ-003 The module SHALL have parameter NRD, default 3, meaning read port count (1..4).
REQ-004 The module SHALL have parameter ZERO_REG, default 1, meaning register 0 hardwired to zero when 1.
REQ-005 The module SHALL have parameter RESET_REGS, default 0, meaning registers cleared on reset when 1.
REQ-006 g_clk  input  1  single clock; all state updates on its rising edge.
REQ-007 g_resetn  input  1  reset, synchronous, active-low.
REQ-008 rs_addr  input  NRD*AW  read addresses, port k at bits [k*AW +: AW].
REQ-009 rs_data  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-010 rs_busy  output  NRD  port k register has an outstanding long-latency write.
REQ-011 wa_en, wa_addr, wa_data  input  1/AW/XLEN  write port A (pipeline writeback).
REQ-012 wb_en, wb_addr, wb_data  input  1/AW/XLEN  write port B (long-latency unit writeback).
REQ-013 lock_en, lock_addr  input  1/AW  mark register busy (long-latency op issued).
REQ-014 flush  input  1  clear all busy bits (pipeline flush).
REQ-015 busy_any  output  1  OR of all busy bits.

Function
REQ-016 Reads SHALL be combinational: rs_data[k] = forwarded value, else stored register.
REQ-017 Forwarding SHALL select wa_data if wa_en and wa_addr==rs_addr[k]; else wb_data if wb_en and wb_addr==rs_addr[k]; else stored value.
REQ-018 With ZERO_REG=1, reads of address 0 SHALL return 0 regardless of forwarding; writes and locks to 0 SHALL be ignored.
REQ-019 Writes SHALL take effect at the next rising edge; a write with en low SHALL not change state.
REQ-020 Both ports writing the same address in one cycle SHALL store wa_data (port A priority).
REQ-021 Each register SHALL own a busy bit; lock_en sets busy[lock_addr] at the next edge.
REQ-022 wb_en SHALL clear busy[wb_addr] at the next edge; wa_en SHALL NOT affect busy bits.
REQ-023 lock_en and wb_en to the same address in one cycle SHALL leave busy set (lock wins).
REQ-024 flush SHALL clear all busy bits at the next edge and SHALL override a same-cycle lock_en; register writes in that cycle SHALL still occur.
REQ-025 rs_busy[k] SHALL reflect the registered busy bit for rs_addr[k], cleared combinationally when wb_en and wb_addr==rs_addr[k] (bypass), forced 0 for address 0 with ZERO_REG=1.
REQ-026 busy_any SHALL be the OR of registered busy bits (no bypass).
REQ-027 Read ports SHALL be independent; identical addresses on multiple ports SHALL return identical data.
REQ-028 Addresses >= NREGS cannot occur (NREGS power of two).

Reset
REQ-029 While g_resetn is low at an edge, all busy bits SHALL clear; rs_busy and busy_any SHALL read 0 the following cycle.
REQ-030 With RESET_REGS=1 all registers SHALL reset to 0; with RESET_REGS=0 register contents SHALL be unaffected by reset.
REQ-031 Reset SHALL override same-cycle lock_en, wa_en, wb_en (no write, no lock).
REQ-032 rs_data SHALL remain combinational during reset (forwarding still active).

Verification
REQ-033 Write A x5=0x1234 cycle 0; read rs_addr[0]=5 cycle 0 -> 0x1234 (forward); cycle 1 -> 0x1234 (stored).
REQ-034 wa and wb both to x7 (0xAAAA / 0xBBBB) same cycle -> rs_data=0xAAAA in that cycle and after.
REQ-035 lock x9; next cycle rs_busy=1, busy_any=1; wb x9=0x55 -> rs_busy=0 that cycle (bypass), busy_any=0 next cycle, data 0x55.
REQ-036 lock x3 and wb x3 same cycle -> busy[3]=1 after; lock x3 with flush -> busy[3]=0, busy_any=0.
REQ-037 Write x0=0xFFFF on both ports, lock x0 -> all reads of x0 return 0, rs_busy=0.
REQ-038 Set busy x1,x2, assert g_resetn=0 with lock x4 -> busy_any=0 after; RESET_REGS=1 build reads x1=0.
